// File: rtl/tx_share_arbiter.sv
module tx_share_arbiter #(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = 12,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          src_req,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_busy,
  output logic                      tx_req,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [3:0]                grant_id,
  output logic [15:0]               pkt_count,
  output logic                      timeout_err,
  output logic                      drop_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam state_t S_AFTER_PKT = (GAP == 0) ? S_IDLE : S_GAP;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t            state;
  logic [N_SRC-1:0]  pending;
  logic [DATA_W-1:0] slot [N_SRC];
  logic [3:0]        rr_ptr;
  logic [TW-1:0]     to_cnt;
  logic [GW-1:0]     gap_cnt;

  logic              pick_found;
  logic [3:0]        pick_idx;
  logic [DATA_W-1:0] pick_data;
  logic              ack_timeout;
  logic              pkt_done;
  logic [N_SRC-1:0]  cap_mask;
  logic [N_SRC-1:0]  clr_mask;

  assign src_busy = pending;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr) + k) % N_SRC;
      if (!pick_found && ((pending & (N_SRC'(1) << cand)) != '0)) begin
        pick_found = 1'b1;
        pick_idx   = 4'(cand);
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (i == 32'(pick_idx)) pick_data = slot[i];
    end
  end

  assign ack_timeout = (state == S_WAIT_ACK) && !tx_busy && (to_cnt == TW'(TIMEOUT - 1));
  assign pkt_done    = (state == S_WAIT_DONE) && !tx_busy;

  // Captures use pre-edge pending bits, so a request on the release edge is dropped.
  assign cap_mask = src_req & ~pending;
  assign clr_mask = (ack_timeout || pkt_done) ? (N_SRC'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pending     <= '0;
      rr_ptr      <= 4'(N_SRC - 1);
      to_cnt      <= '0;
      gap_cnt     <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      pkt_count   <= '0;
      timeout_err <= 1'b0;
      drop_err    <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) slot[i] <= '0;
    end else begin
      pending <= (pending | cap_mask) & ~clr_mask;
      if ((src_req & pending) != '0) drop_err <= 1'b1;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (cap_mask[i]) slot[i] <= src_data[i*DATA_W +: DATA_W];
      end

      tx_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            rr_ptr   <= pick_idx;
            tx_data  <= pick_data;
            tx_req   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt  <= '0;
          gap_cnt <= '0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (ack_timeout) begin
            timeout_err <= 1'b1;
            state       <= S_AFTER_PKT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (pkt_done) begin
            pkt_count <= pkt_count + 16'd1;
            state     <= S_AFTER_PKT;
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) state <= S_IDLE;
          else                         gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
